// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: RV32I load/store
// funct3 encodings, the arbiter FSM state type and the latched request record.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic                   we;
    logic [2:0]             func3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake plus the data_mem port of the arbiter.
// slave = arbiter side, master = requesters and memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             req_we;
  logic [1:0][2:0]        req_func3;

  logic [1:0]             rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_we;
  logic [2:0]             mem_func3;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_func3, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_we, mem_func3
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_func3, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_we, mem_func3
  );
endinterface

// File: rtl/dmem_access_check.sv
// Combinational legality and alignment check of a load/store request.
// err=1 means the access must not reach data_mem.
module dmem_access_check
  import dmem_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       we,
  input  logic [1:0] addr_lo,
  output logic       err
);

  logic legal;
  logic misaligned;

  always_comb begin
    legal = 1'b0;
    case (func3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !we;   // unsigned variants exist only for loads
      default:          legal = 1'b0;
    endcase
    misaligned = (((func3 == F3_H) || (func3 == F3_HU)) && addr_lo[0]) ||
                 ((func3 == F3_W) && (addr_lo != 2'b00));
    err = !legal || misaligned;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data_mem: one request
// per IDLE->ACCESS->RESP round, rejected accesses skip ACCESS entirely.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RR_MODE  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_t        state_q, state_d;
  dmem_req_t         lat_q, sel;
  logic              owner_q, last_gnt_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              win_id, win_vld, acc_err, accept;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  // Winner selection and request mux
  always_comb begin
    win_vld = |bus.req_valid;
    if (RR_MODE != 0)
      win_id = (bus.req_valid == 2'b11) ? ~last_gnt_q : bus.req_valid[1];
    else
      win_id = bus.req_valid[1] &&
               (!bus.req_valid[0] || (wait_cnt_q >= CNT_W'(MAX_WAIT)));
    sel.addr  = DMEM_ADDR_W'(bus.req_addr[win_id]);
    sel.wdata = DMEM_DATA_W'(bus.req_wdata[win_id]);
    sel.we    = bus.req_we[win_id];
    sel.func3 = bus.req_func3[win_id];
  end

  dmem_access_check u_check (
    .func3   (sel.func3),
    .we      (sel.we),
    .addr_lo (sel.addr[1:0]),
    .err     (acc_err)
  );

  always_comb begin
    state_d = state_q;
    gnt     = 2'b00;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt     = win_id ? 2'b10 : 2'b01;
          state_d = acc_err ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == IDLE) && win_vld;

  // Control: state, ownership, round-robin pointer, starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q    <= win_id;
        last_gnt_q <= win_id;
      end
      if (!bus.req_valid[1])
        wait_cnt_q <= '0;
      else if (accept) begin
        if (win_id)
          wait_cnt_q <= '0;
        else if (wait_cnt_q < CNT_W'(MAX_WAIT))
          wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end
  end

  // Data: request latch and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= '0;
        if (!acc_err)
          lat_q <= sel;   // rejected requests leave the memory bus untouched
      end else if ((state_q == ACCESS) && !lat_q.we) begin
        rsp_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Ready is forced low while reset is asserted so all outputs read zero.
  assign bus.req_ready = rst_n ? gnt : 2'b00;
  assign bus.rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_addr  = ADDR_W'(lat_q.addr);
  assign bus.mem_wdata = DATA_W'(lat_q.wdata);
  assign bus.mem_func3 = lat_q.func3;
  assign bus.mem_we    = (state_q == ACCESS) && lat_q.we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance and a fixed-priority
// instance sharing a small byte-addressed data_mem model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bf ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(1), .MAX_WAIT(4)) dut (
    .clk (clk), .rst_n (rst_n), .bus (b0)
  );
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(0), .MAX_WAIT(4)) dut_fp (
    .clk (clk), .rst_n (rst_n), .bus (bf)
  );

  logic [63:0][7:0] mem = '0;
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  function automatic logic [31:0] mem_read(input logic [63:0][7:0] m,
                                           input logic [31:0] addr,
                                           input logic [2:0] f3);
    logic [5:0] a;
    logic [7:0] y0, y1, y2, y3;
    a  = addr[5:0];
    y0 = m[a];
    y1 = m[a + 6'd1];
    y2 = m[a + 6'd2];
    y3 = m[a + 6'd3];
    case (f3)
      3'b000:  return {{24{y0[7]}}, y0};
      3'b001:  return {{16{y1[7]}}, y1, y0};
      3'b010:  return {y3, y2, y1, y0};
      3'b100:  return {24'h0, y0};
      3'b101:  return {16'h0, y1, y0};
      default: return 32'h0;
    endcase
  endfunction

  always_comb b0.mem_rdata = mem_read(mem, b0.mem_addr, b0.mem_func3);
  always_comb bf.mem_rdata = mem_read(mem, bf.mem_addr, bf.mem_func3);

  wire [5:0] wa = b0.mem_addr[5:0];
  always @(posedge clk) begin
    if (b0.mem_we) begin
      we_cnt <= we_cnt + 1;
      mem[wa] <= b0.mem_wdata[7:0];
      if (b0.mem_func3[1:0] != 2'b00) mem[wa + 6'd1] <= b0.mem_wdata[15:8];
      if (b0.mem_func3[1:0] == 2'b10) begin
        mem[wa + 6'd2] <= b0.mem_wdata[23:16];
        mem[wa + 6'd3] <= b0.mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // One complete transaction on the round-robin instance, starting in IDLE.
  task automatic do_req(input bit id, input bit we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input bit exp_err, input logic [31:0] exp_rd, input string tag);
    int w0;
    logic [1:0] oh;
    oh = id ? 2'b10 : 2'b01;
    b0.req_addr[id]  = addr;
    b0.req_wdata[id] = wd;
    b0.req_we[id]    = we;
    b0.req_func3[id] = f3;
    b0.req_valid     = oh;
    #1;
    check({tag, ".ready"}, 32'(b0.req_ready), 32'(oh));
    w0 = we_cnt;
    cyc();
    b0.req_valid = 2'b00;
    #1;
    if (!exp_err) begin
      check({tag, ".mem_we"}, 32'(b0.mem_we), 32'(we));
      check({tag, ".mem_addr"}, b0.mem_addr, addr);
      cyc();
    end
    check({tag, ".rsp_valid"}, 32'(b0.rsp_valid), 32'(oh));
    check({tag, ".rsp_err"}, 32'(b0.rsp_err), 32'(exp_err));
    check({tag, ".rsp_rdata"}, b0.rsp_rdata, exp_rd);
    check({tag, ".mem_we_resp"}, 32'(b0.mem_we), 32'h0);
    check({tag, ".write_count"}, 32'(we_cnt - w0), (!exp_err && we) ? 32'd1 : 32'd0);
    cyc();
    check({tag, ".rsp_idle"}, 32'(b0.rsp_valid), 32'h0);
  endtask

  initial begin
    int w0;
    logic [1:0] oh;
    b0.req_valid = 2'b01; b0.req_addr = '0; b0.req_wdata = '0;
    b0.req_we = '0; b0.req_func3 = '0;
    bf.req_valid = 2'b00; bf.req_addr = '0; bf.req_wdata = '0;
    bf.req_we = '0; bf.req_func3 = '0;

    // Reset state, with a valid request held against the reset
    #12;
    check("rst.ready", 32'(b0.req_ready), 32'h0);
    check("rst.rsp_valid", 32'(b0.rsp_valid), 32'h0);
    check("rst.rsp_rdata", b0.rsp_rdata, 32'h0);
    check("rst.mem_we", 32'(b0.mem_we), 32'h0);
    check("rst.mem_addr", b0.mem_addr, 32'h0);
    b0.req_valid = 2'b00;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Store then loads of several widths
    do_req(1'b0, 1'b1, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0, "sw0");
    do_req(1'b0, 1'b1, 32'h4, 3'b010, 32'h11223344, 1'b0, 32'h0, "sw4");
    do_req(1'b0, 1'b0, 32'h0, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, "lw0");
    do_req(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 32'hFFFFFFEF, "lb0");
    do_req(1'b0, 1'b0, 32'h0, 3'b101, 32'h0, 1'b0, 32'h0000BEEF, "lhu0");

    // Rejected accesses on requester 1
    do_req(1'b1, 1'b0, 32'h2, 3'b010, 32'h0, 1'b1, 32'h0, "lw_mis");
    do_req(1'b1, 1'b1, 32'h1, 3'b001, 32'hCAFE, 1'b1, 32'h0, "sh_mis");
    do_req(1'b1, 1'b0, 32'h0, 3'b011, 32'h0, 1'b1, 32'h0, "f3_011");
    do_req(1'b1, 1'b1, 32'h0, 3'b100, 32'h0, 1'b1, 32'h0, "sbu");
    do_req(1'b1, 1'b0, 32'h0, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, "lw_after_err");

    // Round robin with both requesters continuously valid
    b0.req_addr[0] = 32'h0; b0.req_we[0] = 1'b0; b0.req_func3[0] = 3'b010;
    b0.req_addr[1] = 32'h4; b0.req_we[1] = 1'b0; b0.req_func3[1] = 3'b010;
    b0.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("rr%0d.ready", k), 32'(b0.req_ready), 32'(oh));
      cyc();
      cyc();
      check($sformatf("rr%0d.rsp_valid", k), 32'(b0.rsp_valid), 32'(oh));
      check($sformatf("rr%0d.rdata", k), b0.rsp_rdata,
            (k % 2 == 0) ? 32'hDEADBEEF : 32'h11223344);
      cyc();
    end
    b0.req_valid = 2'b00;
    cyc();

    // Fixed priority with anti-starvation
    bf.req_addr[0] = 32'h0; bf.req_func3[0] = 3'b010;
    bf.req_addr[1] = 32'h4; bf.req_func3[1] = 3'b010;
    bf.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      oh = (k == 4) ? 2'b10 : 2'b01;
      check($sformatf("fp%0d.ready", k), 32'(bf.req_ready), 32'(oh));
      cyc();
      cyc();
      check($sformatf("fp%0d.rsp_valid", k), 32'(bf.rsp_valid), 32'(oh));
      check($sformatf("fp%0d.rdata", k), bf.rsp_rdata,
            (k == 4) ? 32'h11223344 : 32'hDEADBEEF);
      cyc();
    end
    bf.req_valid = 2'b00;
    cyc();

    // Reset during the ACCESS cycle of a store
    b0.req_addr[0] = 32'h4; b0.req_wdata[0] = 32'hDDEEFFAA;
    b0.req_we[0] = 1'b1; b0.req_func3[0] = 3'b010;
    b0.req_valid = 2'b01;
    #1;
    check("abort.ready", 32'(b0.req_ready), 32'h1);
    cyc();
    b0.req_valid = 2'b00;
    #1;
    check("abort.mem_we_access", 32'(b0.mem_we), 32'h1);
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    check("abort.mem_we", 32'(b0.mem_we), 32'h0);
    check("abort.rsp_valid", 32'(b0.rsp_valid), 32'h0);
    check("abort.mem_addr", b0.mem_addr, 32'h0);
    check("abort.mem_wdata", b0.mem_wdata, 32'h0);
    cyc();
    check("abort.rsp_valid_later", 32'(b0.rsp_valid), 32'h0);
    check("abort.write_count", 32'(we_cnt - w0), 32'h0);
    rst_n = 1'b1;
    cyc();
    do_req(1'b0, 1'b0, 32'h4, 3'b010, 32'h0, 1'b0, 32'h11223344, "lw4_after_abort");

    // Requester 0 withdraws while requester 1 keeps its request
    b0.req_addr[1] = 32'h0; b0.req_we[1] = 1'b0; b0.req_func3[1] = 3'b010;
    b0.req_addr[0] = 32'h4; b0.req_we[0] = 1'b0; b0.req_func3[0] = 3'b010;
    b0.req_valid = 2'b10;
    #1;
    check("wd.ready_first", 32'(b0.req_ready), 32'h2);
    cyc();
    b0.req_valid = 2'b11;
    #1;
    check("wd.ready_busy", 32'(b0.req_ready), 32'h0);
    cyc();
    check("wd.rsp_first", 32'(b0.rsp_valid), 32'h2);
    b0.req_valid = 2'b10;
    cyc();
    check("wd.ready_second", 32'(b0.req_ready), 32'h2);
    cyc();
    b0.req_valid = 2'b00;
    cyc();
    check("wd.rsp_second", 32'(b0.rsp_valid), 32'h2);
    check("wd.rdata", b0.rsp_rdata, 32'hDEADBEEF);
    cyc();
    check("wd.rsp_idle", 32'(b0.rsp_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
